// File: rtl/gf12_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gf12_pkg
// Description : Shared GF(2^12) constants, types, FSM encoding and a
//               bit-serial reference reduction function.
// Revision    : 1.0 - initial release
// ============================================================================
package gf12_pkg;

    localparam int M      = 12;
    localparam int PROD_W = 2 * M - 1;
    localparam logic [M:0] POLY = 13'h1009;

    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [M-1:0]      elem_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic elem_t gf_reduce_ref(prod_t p);
        prod_t r;
        r = p;
        for (int i = PROD_W - 1; i >= M; i--) begin
            if (r[i]) begin
                r = r ^ (prod_t'(POLY) << (i - M));
            end
        end
        return r[M-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf_fold_bit.sv
`default_nettype none
// ============================================================================
// Module      : gf_fold_bit
// Description : Folds one bit position of a GF(2)[x] operand by XORing in the
//               modulus shifted to that position when the bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module gf_fold_bit #(
    parameter int         W    = 23,
    parameter int         M    = 12,
    parameter logic [M:0] POLY = 13'h1009
) (
    input  logic [W-1:0]         i_r,
    input  logic [$clog2(W)-1:0] i_pos,
    input  logic                 i_en,
    output logic [W-1:0]         o_r
);

    localparam int c_pos_w = $clog2(W);

    logic [c_pos_w-1:0] w_shamt;
    logic [W-1:0]       w_mask;

    // The shift amount wraps when i_pos < M, but i_en masks that case.
    assign w_shamt = i_pos - c_pos_w'(M);
    assign w_mask  = W'(POLY) << w_shamt;
    assign o_r     = (i_en && i_r[i_pos]) ? (i_r ^ w_mask) : i_r;

endmodule
`default_nettype wire

// File: rtl/gf12_serial_reducer.sv
`default_nettype none
// ============================================================================
// Module      : gf12_serial_reducer
// Description : Digit-serial reduction of a 23-bit GF(2)[x] product modulo
//               x^12+x^3+1, D bits per clock, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module gf12_serial_reducer #(
    parameter int         M    = gf12_pkg::M,
    parameter logic [M:0] POLY = gf12_pkg::POLY,
    parameter int         D    = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*M-2:0] in_prod,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M-1:0]   out_res,
    output logic           busy
);

    import gf12_pkg::*;

    localparam int c_prod_w = 2 * M - 1;
    localparam int c_n      = (M - 1 + D - 1) / D;
    localparam int c_cnt_w  = (c_n > 1) ? $clog2(c_n) : 1;
    localparam int c_pos_w  = $clog2(c_prod_w);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_n - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_prod_w-1:0] r_work;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [M-1:0]        r_res;
    logic                w_load;
    logic                w_last;

    logic [c_prod_w-1:0] w_chain [D+1];
    logic [c_pos_w-1:0]  w_pos   [D];

    assign w_chain[0] = r_work;

    // Digit k of this cycle folds position (top - cnt*D - k), highest first.
    for (genvar k = 0; k < D; k++) begin : g_fold
        assign w_pos[k] = c_pos_w'(c_prod_w - 1 - k) - c_pos_w'(r_cnt) * c_pos_w'(D);

        gf_fold_bit #(
            .W    (c_prod_w),
            .M    (M),
            .POLY (POLY)
        ) u_fold (
            .i_r   (w_chain[k]),
            .i_pos (w_pos[k]),
            .i_en  (w_pos[k] >= c_pos_w'(M)),
            .o_r   (w_chain[k+1])
        );
    end

    assign w_last  = (r_state == ST_REDUCE) && (r_cnt == c_cnt_last);
    assign out_res = r_res;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                busy = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_REDUCE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_work <= in_prod;
                r_cnt  <= '0;
            end else if (r_state == ST_REDUCE) begin
                r_work <= w_chain[D];
                r_cnt  <= r_cnt + 1'b1;
            end
            // Result is captured once so it holds while a new operand loads.
            if (w_last) begin
                r_res <= w_chain[D][M-1:0];
            end
        end
    end

    a_high_cleared : assert property (@(posedge clk) disable iff (rst)
        w_last |-> (w_chain[D][c_prod_w-1:M] == '0));

endmodule
`default_nettype wire
